// File: rtl/issue_pkg.sv
// MIPS instruction field layout and register-usage helpers shared by the issue
// logic and the lane-2 forwarding logic.
package issue_pkg;

  localparam int OPC_LSB  = 26;
  localparam int RS_LSB   = 21;
  localparam int RT_LSB   = 16;
  localparam int RD_LSB   = 11;
  localparam int FUNC_LSB = 0;
  localparam int OPC_W    = 6;
  localparam int REG_W    = 5;
  localparam int FUNC_W   = 6;

  localparam logic [OPC_W-1:0] RTYPE_OPCODE = 6'b000000;

  typedef logic [REG_W-1:0] reg_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_LSB +: OPC_W];
  endfunction

  function automatic reg_t rs_of(input logic [31:0] instr);
    return instr[RS_LSB +: REG_W];
  endfunction

  function automatic reg_t rt_of(input logic [31:0] instr);
    return instr[RT_LSB +: REG_W];
  endfunction

  function automatic reg_t rd_of(input logic [31:0] instr);
    return instr[RD_LSB +: REG_W];
  endfunction

  // Only R-type reads rt as a source; I-type uses rt as its destination.
  function automatic logic reads_rt(input logic [31:0] instr);
    return opcode_of(instr) == RTYPE_OPCODE;
  endfunction

  // Destination picked on opcode class alone, func is deliberately ignored.
  function automatic reg_t dest_reg(input logic [31:0] instr);
    return (opcode_of(instr) == RTYPE_OPCODE) ? rd_of(instr) : rt_of(instr);
  endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational check: does the younger instruction depend on, or overwrite,
// the older one's destination? Zero latency, no flow control.
module pair_hazard_check
  import issue_pkg::*;
(
  input  logic [31:0] instr1,
  input  logic [31:0] instr2,
  output logic        hazard
);

  reg_t w_dest1;
  reg_t w_dest2;
  reg_t w_rs2;
  reg_t w_rt2;
  logic w_rt2_used;

  always_comb begin
    w_dest1    = dest_reg(instr1);
    w_dest2    = dest_reg(instr2);
    w_rs2      = rs_of(instr2);
    w_rt2      = rt_of(instr2);
    w_rt2_used = reads_rt(instr2);
  end

  // Writes to $0 are discarded by the register file, so they never conflict.
  assign hazard = (w_dest1 != '0) &&
                  ((w_dest1 == w_rs2) ||
                   (w_rt2_used && (w_dest1 == w_rt2)) ||
                   (w_dest1 == w_dest2));

endmodule

// File: rtl/dual_issue_buffer.sv
// Circular instruction FIFO presenting up to two oldest entries to decode; one cycle
// push-to-lane1 latency, no bypass. in_ready depends only on occupancy and flush.
module dual_issue_buffer
  import issue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  output logic                       in_ready,
  input  logic                       out_ready,
  output logic                       lane1_valid,
  output logic [31:0]                lane1_instr,
  output logic                       lane2_valid,
  output logic [31:0]                lane2_instr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           split_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_split_cnt;

  logic [PTR_W-1:0] w_rd_ptr1;
  logic [31:0]      w_head;
  logic [31:0]      w_next;
  logic             w_has1;
  logic             w_has2;
  logic             w_hazard;
  logic             w_lane2_ok;
  logic             w_push;
  logic [1:0]       w_pop_cnt;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  always_comb begin
    w_rd_ptr1 = r_rd_ptr + PTR_W'(1);
    w_head    = r_mem[r_rd_ptr];
    w_next    = r_mem[w_rd_ptr1];
    w_has1    = (r_count != '0);
    w_has2    = (r_count >= CW'(2));
  end

  pair_hazard_check u_hazard (
    .instr1 (w_head),
    .instr2 (w_next),
    .hazard (w_hazard)
  );

  assign w_lane2_ok = w_has2 && !w_hazard;
  assign in_ready   = !flush && (r_count != FULL_CNT);
  assign w_push     = in_valid && in_ready;

  always_comb begin
    w_pop_cnt = 2'd0;
    if (out_ready) begin
      if (w_lane2_ok) begin
        w_pop_cnt = 2'd2;
      end else if (w_has1) begin
        w_pop_cnt = 2'd1;
      end
    end
  end

  assign lane1_valid = w_has1;
  assign lane2_valid = w_lane2_ok;
  assign lane1_instr = w_has1     ? w_head : 32'h0;
  assign lane2_instr = w_lane2_ok ? w_next : 32'h0;
  assign count       = r_count;
  assign split_cnt   = r_split_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_cnt);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop_cnt);
    end
  end

  // Counts stalled pairing opportunities; kept across flush for performance stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_split_cnt <= '0;
    end else if (out_ready && w_has2 && w_hazard && (r_split_cnt != '1)) begin
      r_split_cnt <= r_split_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_instr;
    end
  end

endmodule
